// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: issues RV32M mul/div ops to an unsigned multi-cycle engine.
// Handles operand sign stripping, divide-by-zero and signed-overflow presets,
// sign correction of the 64-bit engine output, and pipeline stall.
//
// state | meaning
// IDLE  | waiting for a request; special-case divides resolve here
// ISSUE | md_valid pulse to the engine
// WAIT  | engine busy, waiting for md_ready
// FIX   | sign-correct and select the 32-bit result
// DONE  | result_valid pulse
// DRAIN | killed op still in the engine; swallow its md_ready
module muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic              flush,
    output logic              stall,
    output logic [XLEN-1:0]   result,
    output logic              result_valid,
    output logic              md_valid,
    output logic              md_mode,
    output logic [XLEN-1:0]   md_a,
    output logic [XLEN-1:0]   md_b,
    input  logic              md_ready,
    input  logic [2*XLEN-1:0] md_out
);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_FIX, S_DONE, S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              mode_q, mode_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2*XLEN-1:0] prod_q, prod_d;

    logic              sign1, sign2, dec_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   abs1, abs2, dec_a, dec_b, preset;
    logic [2*XLEN-1:0] prod_neg;
    logic [XLEN-1:0]   div_sel, div_fix, fix_res;

    // Decode the incoming request: magnitudes, result sign, special-case presets
    always_comb begin
        sign1   = rs1[XLEN-1];
        sign2   = rs2[XLEN-1];
        abs1    = sign1 ? -rs1 : rs1;
        abs2    = sign2 ? -rs2 : rs2;
        dec_a   = rs1;
        dec_b   = rs2;
        dec_neg = 1'b0;
        case (funct3)
            3'b001, 3'b100: begin dec_a = abs1; dec_b = abs2; dec_neg = sign1 ^ sign2; end
            3'b110:         begin dec_a = abs1; dec_b = abs2; dec_neg = sign1; end
            3'b010:         begin dec_a = abs1; dec_neg = sign1; end
            default:        ;
        endcase
        div_zero = funct3[2] && (rs2 == '0);
        div_ovf  = funct3[2] && !funct3[0] && (rs1 == INT_MIN) && (rs2 == '1);
        // funct3[1] selects remainder vs quotient for the preset
        if (funct3[1]) preset = div_zero ? rs1 : '0;
        else           preset = div_zero ? '1 : INT_MIN;
    end

    // Sign correction and word select on the captured engine output
    always_comb begin
        prod_neg = neg_q ? -prod_q : prod_q;
        div_sel  = op_q[1] ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
        div_fix  = neg_q ? -div_sel : div_sel;
        if (op_q[2])               fix_res = div_fix;
        else if (op_q[1:0] == 2'b00) fix_res = prod_neg[XLEN-1:0];
        else                       fix_res = prod_neg[2*XLEN-1:XLEN];
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        prod_d   = prod_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    op_d   = funct3;
                    neg_d  = dec_neg;
                    mode_d = funct3[2];
                    a_d    = dec_a;
                    b_d    = dec_b;
                    if (div_zero || div_ovf) begin
                        result_d = preset;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_ISSUE;
                    end
                end
            end
            // engine has already seen md_valid, so a flush must drain it
            S_ISSUE: state_d = flush ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (flush) begin
                    state_d = md_ready ? S_IDLE : S_DRAIN;
                end else if (md_ready) begin
                    prod_d  = md_out;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = fix_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_DRAIN: if (md_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            mode_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            prod_q   <= prod_d;
        end
    end

    assign stall = ((state_q == S_IDLE) && req_valid && !flush) ||
                   (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_FIX) ||
                   ((state_q == S_DRAIN) && req_valid);
    assign result_valid = (state_q == S_DONE) && !flush;
    assign md_valid     = (state_q == S_ISSUE);
    assign md_mode      = mode_q;
    assign md_a         = a_q;
    assign md_b         = b_q;
    assign result       = result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: mock unsigned engine, reference model,
// scoreboard queue of expected results.
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        stall, result_valid, md_valid, md_mode;
    logic [31:0] result, md_a, md_b;
    logic        md_ready = 1'b0;
    logic [63:0] md_out = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rv_cnt  = 0;
    int mv_cnt  = 0;
    logic [31:0] exp_q[$];

    int          eng_lat  = 4;
    bit          eng_busy = 1'b0;
    int          eng_cnt  = 0;
    logic [31:0] eng_a    = '0;
    logic [31:0] eng_b    = '0;
    logic        eng_mode = 1'b0;

    muldiv_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .flush(flush), .stall(stall), .result(result),
        .result_valid(result_valid), .md_valid(md_valid), .md_mode(md_mode),
        .md_a(md_a), .md_b(md_b), .md_ready(md_ready), .md_out(md_out)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end
    initial forever begin
        @(negedge clk); #2;
        if (result_valid) rv_cnt++;
        if (md_valid) mv_cnt++;
    end

    // mock engine: md_ready N cycles after md_valid, garbage on md_out otherwise
    initial forever begin
        @(negedge clk);
        md_ready = 1'b0;
        md_out   = {$urandom, $urandom};
        if (eng_busy) begin
            if (md_valid) begin
                n_fail++;
                $display("FAIL engine_protocol: md_valid=1 while engine busy, required 0");
            end
            eng_cnt--;
            if (eng_cnt <= 0) begin
                eng_busy = 1'b0;
                md_ready = 1'b1;
                if (eng_mode) md_out = (eng_b == 0) ? {eng_a, 32'hFFFF_FFFF} : {eng_a % eng_b, eng_a / eng_b};
                else          md_out = {32'b0, eng_a} * {32'b0, eng_b};
            end
        end else if (md_valid) begin
            eng_busy = 1'b1;
            eng_cnt  = eng_lat;
            eng_a    = md_a;
            eng_b    = md_b;
            eng_mode = md_mode;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub;
        logic [63:0] p;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        ref_res = '0;
        case (f)
            3'b000: begin p = sa * sb; ref_res = p[31:0]; end
            3'b001: begin p = sa * sb; ref_res = p[63:32]; end
            3'b010: begin p = sa * ub; ref_res = p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; ref_res = p[63:32]; end
            3'b100: ref_res = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            3'b101: ref_res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: ref_res = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: ref_res = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7;
            default: return $urandom;
        endcase
    endfunction

    // Drive one request, hold it while stalled, check result, latency and stall.
    // b2b: request raised in the DONE cycle of the previous op, so it is seen one cycle later.
    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input bit b2b);
        int c0, seen, exp_lat;
        bit stall_bad, done_stall;
        logic [31:0] exp;
        if (!b2b) @(negedge clk);
        eng_lat = lat;
        exp_lat = (is_special(f, a, b) ? 1 : 3 + lat) + (b2b ? 1 : 0);
        exp_q.push_back(ref_res(f, a, b));
        funct3 = f; rs1 = a; rs2 = b; flush = 1'b0; req_valid = 1'b1;
        c0 = cyc; seen = -1; stall_bad = 1'b0; done_stall = 1'b1;
        for (int i = 0; i < lat + 12; i++) begin
            @(negedge clk);
            if (result_valid) begin seen = cyc - c0; done_stall = stall; break; end
            if (i > 0 || !b2b) if (stall !== 1'b1) stall_bad = 1'b1;
        end
        req_valid = 1'b0;
        exp = exp_q.pop_front();
        n_tests++;
        if (seen < 0) begin
            n_fail++;
            $display("FAIL %s_timeout: no result_valid within %0d cycles, required one", nm, lat + 12);
        end else begin
            if (result !== exp) begin
                n_fail++;
                $display("FAIL %s_result: got %h, expected %h (f3=%b a=%h b=%h)", nm, result, exp, f, a, b);
            end
            n_tests++;
            if (seen != exp_lat) begin
                n_fail++;
                $display("FAIL %s_latency: got %0d cycles, expected %0d", nm, seen, exp_lat);
            end
            n_tests++;
            if (stall_bad || done_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_stall: busy-stall gap=%0d done-stall=%b, expected 0/0", nm, stall_bad, done_stall);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({stall, result_valid, md_valid, md_mode} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, expected 0000", {stall, result_valid, md_valid, md_mode});
        end
        n_tests++;
        if ({result, md_a, md_b} !== 96'b0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h/%h, expected all zero", result, md_a, md_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b0 || result_valid !== 1'b0 || md_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: stall=%b rv=%b mv=%b, expected 0", stall, result_valid, md_valid);
        end
    endtask

    task automatic test_mulh();
        int rv0, mv0;
        rv0 = rv_cnt; mv0 = mv_cnt;
        run_op("mulh_neg3x5", 3'b001, 32'hFFFF_FFFD, 32'd5, 32, 1'b0);
        n_tests++;
        if (eng_a !== 32'd3 || eng_b !== 32'd5 || eng_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL mulh_issue: md_a=%h md_b=%h mode=%b, expected 3/5/0", eng_a, eng_b, eng_mode);
        end
        @(negedge clk);
        n_tests++;
        if (result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mulh_pulse: result_valid=%b one cycle after DONE, expected 0", result_valid);
        end
        @(negedge clk);
        n_tests++;
        if (rv_cnt != rv0 + 1 || mv_cnt != mv0 + 1) begin
            n_fail++;
            $display("FAIL mulh_pulses: rv=%0d mv=%0d, expected 1/1", rv_cnt - rv0, mv_cnt - mv0);
        end
    endtask

    task automatic test_special();
        int mv0;
        mv0 = mv_cnt;
        run_op("div_by_zero",  3'b100, 32'd7, 32'd0, 4, 1'b0);
        run_op("remu_by_zero", 3'b111, 32'd7, 32'd0, 4, 1'b0);
        run_op("div_overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 4, 1'b0);
        run_op("rem_overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 4, 1'b0);
        @(negedge clk);
        n_tests++;
        if (mv_cnt != mv0) begin
            n_fail++;
            $display("FAIL special_no_issue: md_valid pulses %0d, expected 0", mv_cnt - mv0);
        end
    endtask

    task automatic test_signed();
        run_op("rem_neg7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 3, 1'b0);
        run_op("div_neg7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 3, 1'b0);
        run_op("div_neg7_neg2",3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 2, 1'b0);
        run_op("rem_7_neg2",   3'b110, 32'd7, 32'hFFFF_FFFE, 2, 1'b0);
        run_op("mulh_min_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 5, 1'b0);
        run_op("mulhsu_m1",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0);
        run_op("mul_neg3x5",   3'b000, 32'hFFFF_FFFD, 32'd5, 1, 1'b0);
    endtask

    task automatic test_flush_short();
        int rv0;
        @(negedge clk);
        rv0 = rv_cnt;
        funct3 = 3'b100; rs1 = 32'd7; rs2 = 32'd0; req_valid = 1'b1; flush = 1'b1; #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_stall: stall=%b, expected 0", stall);
        end
        @(negedge clk); req_valid = 1'b0; flush = 1'b0; #1;
        n_tests++;
        if (result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_accept: result_valid=%b, expected 0", result_valid);
        end
        @(negedge clk); funct3 = 3'b101; rs1 = 32'd9; rs2 = 32'd0; req_valid = 1'b1;
        @(negedge clk); req_valid = 1'b0; flush = 1'b1; #1;
        n_tests++;
        if (result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_done_rv: result_valid=%b, expected 0", result_valid);
        end
        @(negedge clk); flush = 1'b0;
        n_tests++;
        if (rv_cnt != rv0) begin
            n_fail++;
            $display("FAIL flush_short_count: %0d result pulses, expected 0", rv_cnt - rv0);
        end
    endtask

    task automatic test_flush_wait();
        int c0, seen, rv0, mv0;
        bit bad;
        logic [31:0] exp;
        @(negedge clk);
        rv0 = rv_cnt; mv0 = mv_cnt;
        eng_lat = 12; funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; req_valid = 1'b1; c0 = cyc;
        repeat (5) @(negedge clk);
        flush = 1'b1; eng_lat = 3; funct3 = 3'b000; rs1 = 32'd6; rs2 = 32'd7;
        exp_q.push_back(ref_res(3'b000, 32'd6, 32'd7));
        @(negedge clk); flush = 1'b0;
        seen = -1; bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (result_valid) begin seen = cyc - c0; break; end
            if (stall !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        req_valid = 1'b0;
        exp = exp_q.pop_front();
        n_tests++;
        if (seen != 20 || result !== exp) begin
            n_fail++;
            $display("FAIL flush_wait_result: got %h at cycle %0d, expected %h at cycle 20", result, seen, exp);
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL flush_wait_stall: stall dropped while draining, expected 1");
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (rv_cnt != rv0 + 1 || mv_cnt != mv0 + 2) begin
            n_fail++;
            $display("FAIL flush_wait_count: rv=%0d mv=%0d, expected 1/2", rv_cnt - rv0, mv_cnt - mv0);
        end
    endtask

    task automatic test_flush_ready();
        int c0, seen, rv0;
        logic [31:0] exp;
        @(negedge clk);
        rv0 = rv_cnt;
        eng_lat = 4; funct3 = 3'b011; rs1 = 32'h1234_5678; rs2 = 32'h9ABC_DEF0; req_valid = 1'b1; c0 = cyc;
        repeat (5) @(negedge clk);
        flush = 1'b1; eng_lat = 2; funct3 = 3'b111; rs1 = 32'd50; rs2 = 32'd7;
        exp_q.push_back(ref_res(3'b111, 32'd50, 32'd7));
        @(negedge clk); flush = 1'b0;
        seen = -1;
        for (int i = 0; i < 30; i++) begin
            if (result_valid) begin seen = cyc - c0; break; end
            @(negedge clk);
        end
        req_valid = 1'b0;
        exp = exp_q.pop_front();
        n_tests++;
        if (seen != 11 || result !== exp) begin
            n_fail++;
            $display("FAIL flush_ready: got %h at cycle %0d, expected %h at cycle 11", result, seen, exp);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (rv_cnt != rv0 + 1) begin
            n_fail++;
            $display("FAIL flush_ready_count: %0d result pulses, expected 1", rv_cnt - rv0);
        end
    endtask

    task automatic test_reset_abort();
        int rv0;
        bit bad;
        @(negedge clk);
        eng_lat = 20; funct3 = 3'b001; rs1 = 32'hFFFF_FFFD; rs2 = 32'd5; req_valid = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0; req_valid = 1'b0; #1;
        n_tests++;
        if ({stall, result_valid, md_valid, md_mode, result, md_a, md_b} !== 100'b0) begin
            n_fail++;
            $display("FAIL reset_abort_outputs: st=%b rv=%b mv=%b mode=%b res=%h a=%h b=%h, expected all 0",
                     stall, result_valid, md_valid, md_mode, result, md_a, md_b);
        end
        @(negedge clk); rst_n = 1'b1;
        rv0 = rv_cnt; bad = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (result_valid !== 1'b0 || stall !== 1'b0 || md_valid !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad || rv_cnt != rv0) begin
            n_fail++;
            $display("FAIL reset_abort_stray: activity after stray md_ready, rv=%0d, expected none", rv_cnt - rv0);
        end
        run_op("mulhu_after_reset", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f;
        logic [31:0] a, b;
        int lat;
        for (int i = 0; i < 24; i++) begin
            f   = 3'($urandom_range(0, 7));
            a   = pick();
            b   = pick();
            lat = int'($urandom_range(1, 6));
            run_op("b2b", f, a, b, lat, i > 0);
        end
    endtask

    initial begin
        test_reset();
        test_mulh();
        test_special();
        test_signed();
        test_flush_short();
        test_flush_wait();
        test_flush_ready();
        test_reset_abort();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
